mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store controller sitting directly upstream of `data_memory` in the 8-bit datapath. It accepts one load or store request at a time from the CPU core over a valid/ready handshake. It sequences `data_memory`'s `wr`/`rd`/`add`/`data_in` pins with correct setup and read latency, captures `data_out`, and returns a held response until the core accepts it.

## Interface
- `DATA_W`, 8, data width; matches `data_memory`.
- `ADDR_W`, 8, address width; matches `data_memory` `add`.
- `RD_LAT`, 1, number of edges after the `rd`-sampling edge before `data_out` is valid; legal range 0..3.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  store data; ignored for loads.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  core accepts response.
- `resp_rdata`  out  DATA_W  load data, or the written data for a store.
- `busy`  out  1  high in any state except IDLE.
- `mem_wr`  out  1  to `data_memory.wr`.
- `mem_rd`  out  1  to `data_memory.rd`.
- `mem_add`  out  ADDR_W  to `data_memory.add`.
- `mem_data_in`  out  DATA_W  to `data_memory.data_in`.
- `mem_data_out`  in  DATA_W  from `data_memory.data_out`.

## Operation
- FSM states: IDLE, WR, RD, WAIT, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1.
  - On `req_valid && req_ready` at a rising edge, latch `req_addr`, `req_wdata` and `req_we`.
  - Go to WR if `req_we`=1, else RD.
- WR: `mem_wr`=1 for exactly one cycle, then RESP.
- RD: `mem_rd`=1 for exactly one cycle.
  - If `RD_LAT`=0, capture `mem_data_out` on the leaving edge and go to RESP.
  - Otherwise go to WAIT.
- WAIT: counter runs `RD_LAT` cycles. `mem_data_out` is captured on the final edge, then RESP.
- RESP: `resp_valid`=1 and `resp_rdata` is stable.
  - Hold until `resp_ready`=1 at an edge, then IDLE.
  - Store responses return the latched write data.
- `mem_add` and `mem_data_in` are registered. They change only on an accept edge and hold from that edge through RESP.
- `mem_wr` and `mem_rd` are never high together. Both are 0 in IDLE, WAIT and RESP.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there. The next request cannot be accepted in the same cycle as the response handshake.
- Addresses 0x00 and 0xFF pass through unmodified. There is no wrap or increment logic.
- Reset values: `req_ready`=0 while `rst_n`=0, then 1 in the first IDLE cycle. All other outputs are 0 while in reset.

## Timing
- Accept edge E0. Store: `mem_wr` high in cycle E0–E1, memory commits at E1, `resp_valid` high from cycle after E1.
  - Accept-to-response latency is 2 edges.
- Load: `mem_rd` high in cycle E0–E1, capture at E(1+`RD_LAT`), `resp_valid` from the following cycle.
  - Latency is 2+`RD_LAT` edges; 3 at default.
- Throughput with `resp_ready` tied high:
  - Store: one per 3 cycles.
  - Load: one per 3+`RD_LAT` cycles.
- Reset asserted mid-operation clears state, response and memory strobes immediately (asynchronously).
  - An in-flight store is not guaranteed to commit.
  - A pending response is discarded.
- Deassertion of `rst_n` is synchronised externally. The first accept is possible at the first edge after release.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the FSM state enum `mac_state_t`;
  - constants `DATA_W_DEF`=8 and `ADDR_W_DEF`=8.
  `data_memory` and this block share it.
- No sub-module: the 2-bit `RD_LAT` wait counter is inline.
- Top-level wires `mem_*` straight to the `data_memory` instance.

## Test plan
- **Store then load:** store 0xAA to 0x05, then load 0x05 → store `resp_valid` 2 edges after accept; load returns `resp_rdata`=0xAA 3 edges after accept (`RD_LAT`=1); `mem_wr`/`mem_rd` each pulse one cycle.
- **Address boundaries:** store 0x3C to 0xFF and 0xC3 to 0x00, then load both → 0x3C and 0xC3; `mem_add` shows exactly 0xFF/0x00.
- **Response backpressure:** hold `resp_ready`=0 for 5 cycles after a load of 0x05 → `resp_valid` and `resp_rdata`=0xAA stable all 5 cycles; `req_ready`=0; a second `req_valid` is ignored.
- **Reset mid-load:** assert `rst_n`=0 during WAIT → `mem_rd`, `resp_valid` and `busy` go 0 immediately; after release the state is IDLE, `req_ready`=1 and no response is emitted.
- **Back-to-back:** 4 stores to 0x10..0x13 (data 0x01..0x04) with `resp_ready`=1, then 4 loads → data 0x01..0x04 in order; `mem_wr` and `mem_rd` are never high together.
- **`RD_LAT` variation:** `RD_LAT`=0 and `RD_LAT`=3 builds with a matching memory model → load latency of 2 and 5 edges respectively, correct data.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the 8-bit datapath memory path.
// Both mem_access_ctrl and data_memory import this package.
//   mac_state_t : load/store controller FSM state
//   DATA_W_DEF  : default data width
//   ADDR_W_DEF  : default address width
package cpu_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    MAC_IDLE = 3'd0,
    MAC_WR   = 3'd1,
    MAC_RD   = 3'd2,
    MAC_WAIT = 3'd3,
    MAC_RESP = 3'd4
  } mac_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of data_memory.
// Takes one request at a time from the core over valid/ready, drives the
// memory strobes/address/data with correct setup and read latency, then holds
// the response until the core takes it.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata   request payload (1 = store)
//   resp_valid/resp_ready         response handshake
//   resp_rdata                    load data, or the stored data for a store
//   busy                          high in any non-IDLE state
//   mem_wr, mem_rd, mem_add,
//   mem_data_in, mem_data_out     straight to/from data_memory
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1            // 0..3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  // Last value of the wait counter; WAIT spans RD_LAT cycles.
  localparam logic [1:0] WAIT_LAST = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  mac_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              accept;

  // Store vs. load is carried by the WR/RD state itself, so req_we needs no
  // separate register.
  assign accept = (state_q == MAC_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MAC_IDLE: if (req_valid) state_d = req_we ? MAC_WR : MAC_RD;
      MAC_WR: begin
        rdata_d = wdata_q;
        state_d = MAC_RESP;
      end
      MAC_RD: begin
        cnt_d = 2'd0;
        if (RD_LAT == 0) begin
          rdata_d = mem_data_out;
          state_d = MAC_RESP;
        end else begin
          state_d = MAC_WAIT;
        end
      end
      MAC_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rdata_d = mem_data_out;
          state_d = MAC_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      MAC_RESP: if (resp_ready) state_d = MAC_IDLE;
      default:  state_d = MAC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAC_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // rst_n gating keeps ready low during reset even though state_q is IDLE.
  assign req_ready   = rst_n && (state_q == MAC_IDLE);
  assign busy        = (state_q != MAC_IDLE);
  assign resp_valid  = (state_q == MAC_RESP);
  assign resp_rdata  = rdata_q;
  assign mem_wr      = (state_q == MAC_WR);
  assign mem_rd      = (state_q == MAC_RD);
  assign mem_add     = addr_q;
  assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural data_memory and
// a flat reference array of expected memory contents.
module tb_mem_access_ctrl;
  import cpu_mem_pkg::*;

  localparam int RD_LAT = 1;
  localparam int DQ_I   = (RD_LAT == 0) ? 0 : RD_LAT - 1;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       req_valid = 0, req_we = 0, resp_ready = 1;
  logic [7:0] req_addr = 0, req_wdata = 0;
  logic       req_ready, resp_valid, busy, mem_wr, mem_rd;
  logic [7:0] resp_rdata, mem_add, mem_data_in, mem_data_out;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .busy(busy), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_add(mem_add),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Behavioural memory: data is valid RD_LAT edges after the rd-sampling
  // edge; any other time the output shows 0xEE so a mistimed capture shows up.
  logic [7:0] mem [256];
  logic [7:0] dq  [4];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_add] <= mem_data_in;
    dq[0] <= mem_rd ? mem[mem_add] : 8'hEE;
    for (int k = 1; k < 4; k++) dq[k] <= dq[k-1];
  end
  assign mem_data_out = (RD_LAT == 0) ? (mem_rd ? mem[mem_add] : 8'hEE) : dq[DQ_I];

  // Strobe monitor.
  int wr_cnt = 0, rd_cnt = 0, both_hi = 0;
  always @(posedge clk) begin
    if (mem_wr) wr_cnt++;
    if (mem_rd) rd_cnt++;
    if (mem_wr && mem_rd) both_hi++;
  end

  int checks = 0, errors = 0;
  logic [7:0] ref_mem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete transaction with resp_ready high; latency counted in edges
  // starting with the accept edge.
  task automatic do_txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input int explat, input string nm);
    int w0, r0, lat;
    w0 = wr_cnt; r0 = rd_cnt;
    @(negedge clk);
    chk({nm, " req_ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_addr = 8'($urandom); req_wdata = 8'($urandom);
    chk({nm, " mem_add"}, mem_add, a);
    chk({nm, " strobe"}, we ? mem_wr : mem_rd, 1);
    lat = 1;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (resp_valid) break;
    end
    chk({nm, " latency"}, lat, explat);
    chk({nm, " rdata"}, resp_rdata, exp);
    chk({nm, " mem_add hold"}, mem_add, a);
    @(posedge clk); #1;
    chk({nm, " resp done"}, resp_valid, 0);
    chk({nm, " wr pulses"}, wr_cnt - w0, we ? 1 : 0);
    chk({nm, " rd pulses"}, rd_cnt - r0, we ? 0 : 1);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t vt [16];
    logic we;
    logic [7:0] a, d, e;
    bit seen;
    int w0;

    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end

    // Reset state.
    #2;
    chk("rst req_ready", req_ready, 0);
    chk("rst outputs", {resp_valid, busy, mem_wr, mem_rd}, 0);
    chk("rst mem_add", mem_add, 0);
    chk("rst rdata", resp_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1; #1;
    chk("post-rst req_ready", req_ready, 1);

    vt[0]  = '{1, 8'h05, 8'hAA, 8'hAA};
    vt[1]  = '{0, 8'h05, 8'h00, 8'hAA};
    vt[2]  = '{1, 8'hFF, 8'h3C, 8'h3C};
    vt[3]  = '{1, 8'h00, 8'hC3, 8'hC3};
    vt[4]  = '{0, 8'hFF, 8'h00, 8'h3C};
    vt[5]  = '{0, 8'h00, 8'h00, 8'hC3};
    for (int i = 0; i < 4; i++) begin
      vt[6+i]  = '{1, 8'(8'h10 + i), 8'(i + 1), 8'(i + 1)};
      vt[10+i] = '{0, 8'(8'h10 + i), 8'h5A,     8'(i + 1)};
    end
    vt[14] = '{0, 8'h05, 8'h00, 8'hAA};
    vt[15] = '{0, 8'h80, 8'h77, 8'h00};
    for (int i = 0; i < 16; i++) begin
      if (vt[i].we) ref_mem[vt[i].addr] = vt[i].wdata;
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp,
             vt[i].we ? 2 : 2 + RD_LAT, $sformatf("vec%0d", i));
    end

    // Response backpressure on a load of 0x05; a store offered meanwhile
    // must be ignored.
    resp_ready = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 8'h05;
    @(posedge clk); #1;
    req_we = 1; req_wdata = 8'h55;
    w0 = wr_cnt;
    for (int i = 0; i < 20 && !resp_valid; i++) begin @(posedge clk); #1; end
    chk("bp resp_valid", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d", i), {resp_valid, resp_rdata, req_ready}, {1'b1, 8'hAA, 1'b0});
    end
    @(negedge clk); req_valid = 0; resp_ready = 1;
    @(posedge clk); #1;
    chk("bp released", resp_valid, 0);
    chk("bp no write", wr_cnt - w0, 0);
    do_txn(0, 8'h05, 8'h00, 8'hAA, 2 + RD_LAT, "bp reload");

    // Reset in the middle of a load.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 8'h05;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("midrst outputs", {mem_rd, resp_valid, busy, req_ready}, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("midrst ready", {req_ready, busy}, 2'b10);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (resp_valid) seen = 1; end
    chk("midrst no resp", seen, 0);

    // Random traffic against the reference array.
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = (i % 10 == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      e  = we ? d : ref_mem[a];
      if (we) ref_mem[a] = d;
      do_txn(we, a, d, e, we ? 2 : 2 + RD_LAT, $sformatf("rnd%0d", i));
    end

    chk("wr/rd never together", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
